codec_avalon_slave_v2: RTL and testbench

CODEC_AVALON_SLAVE_V2 -- requirements
Module: codec_avalon_slave_v2

---
 rtl/codec_avalon_slave_v2_if.sv | 26 ++
 rtl/codec_avalon_slave_v2.sv | 195 +++++++++++++++++++
 tb/tb_codec_avalon_slave_v2.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/codec_avalon_slave_v2_if.sv
// Avalon-MM slave bus bundle for the codec register block.
// The master modport is the bus-master view, the slave modport is the view taken by the design.
interface codec_avalon_slave_v2_if;
   logic        slave_chipselect;
   logic        slave_read;
   logic        slave_write;
   logic [2:0]  slave_address;
   logic [31:0] slave_writedata;
   logic [31:0] slave_readdata;
   logic        slave_waitrequest;
   logic        slave_beginbursttransfer;
   logic [7:0]  slave_burstcount;
   logic        slave_irq;

   modport master (
      output slave_chipselect, slave_read, slave_write, slave_address,
             slave_writedata, slave_beginbursttransfer, slave_burstcount,
      input  slave_readdata, slave_waitrequest, slave_irq
   );

   modport slave (
      input  slave_chipselect, slave_read, slave_write, slave_address,
             slave_writedata, slave_beginbursttransfer, slave_burstcount,
      output slave_readdata, slave_waitrequest, slave_irq
   );
endinterface

// File: rtl/codec_avalon_slave_v2.sv
// Avalon-MM register slave for an audio codec: I2C command launch, DAC/ADC FIFO data ports,
// threshold/edge interrupts and burst tracking.
module codec_avalon_slave_v2 #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned I2C_W  = 24,
   parameter int unsigned LVL_W  = 8
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   codec_avalon_slave_v2_if.slave  avs,
   input  logic                    i2c_idle,
   output logic [I2C_W-1:0]        i2c_packet,
   output logic                    wr_i2c,
   input  logic                    adc_fifo_empty,
   input  logic [LVL_W-1:0]        adc_fifo_level,
   input  logic [DATA_W-1:0]       adc_fifo_out,
   output logic                    rd_adc_fifo,
   input  logic                    dac_fifo_full,
   input  logic [LVL_W-1:0]        dac_fifo_level,
   output logic [DATA_W-1:0]       dac_fifo_in,
   output logic                    wr_dac_fifo
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RBURST = 2'd1,
      WBURST = 2'd2
   } state_t;

   localparam logic [2:0] A_I2C   = 3'd0;
   localparam logic [2:0] A_STAT  = 3'd1;
   localparam logic [2:0] A_DAC   = 3'd2;
   localparam logic [2:0] A_ADC   = 3'd3;
   localparam logic [2:0] A_MASK  = 3'd4;
   localparam logic [2:0] A_PEND  = 3'd5;
   localparam logic [2:0] A_THR   = 3'd6;
   localparam logic [2:0] A_BURST = 3'd7;
   localparam logic [LVL_W-1:0] LVL_MAX = '1;

   logic [31:0]       r_i2c_cmd;
   logic [DATA_W-1:0] r_dac_in;
   logic              r_wr_dac;
   logic [3:0]        r_mask;
   logic [3:0]        r_pend;
   logic [LVL_W-1:0]  r_adc_thr;
   logic [LVL_W-1:0]  r_dac_thr;
   logic [7:0]        r_remaining;
   state_t            r_state;
   logic              r_prev_adc;
   logic              r_prev_dac;
   logic              r_prev_idle;
   logic              r_irq;

   logic              w_rd;
   logic              w_wr;
   logic              w_wait;
   logic              w_acc_rd;
   logic              w_acc_wr;
   logic              w_beat;
   logic [7:0]        w_rem_load;
   logic              w_burst_done;
   logic [3:0]        w_set;
   logic [3:0]        w_w1c;
   logic [31:0]       w_rdata;
   logic [15:0]       w_adc_lvl16;
   logic [11:0]       w_dac_lvl12;
   logic [15:0]       w_adc_thr16;
   logic [15:0]       w_dac_thr16;

   // Simultaneous read and write is a no-op beat: neither qualifier is seen.
   assign w_rd = avs.slave_chipselect & avs.slave_read & ~avs.slave_write;
   assign w_wr = avs.slave_chipselect & avs.slave_write & ~avs.slave_read;

   always_comb begin
      w_wait = 1'b0;
      if (w_wr) begin
         if (r_state == RBURST)
            w_wait = 1'b1;
         else if (avs.slave_address == A_I2C && !i2c_idle)
            w_wait = 1'b1;
         else if (avs.slave_address == A_DAC &&
                  (dac_fifo_full || (r_wr_dac && dac_fifo_level == LVL_MAX)))
            w_wait = 1'b1;
      end else if (w_rd) begin
         if (r_state == WBURST)
            w_wait = 1'b1;
         else if (avs.slave_address == A_ADC && adc_fifo_empty)
            w_wait = 1'b1;
      end
   end

   assign w_acc_rd     = w_rd & ~w_wait;
   assign w_acc_wr     = w_wr & ~w_wait;
   assign w_beat       = w_acc_rd | w_acc_wr;
   assign w_rem_load   = (avs.slave_burstcount == 8'd0) ? 8'd0 : avs.slave_burstcount - 8'd1;
   assign w_burst_done = (r_state != IDLE) && w_beat && (r_remaining == 8'd1);

   assign w_set = {w_burst_done,
                   i2c_idle & ~r_prev_idle,
                   (dac_fifo_level <= r_dac_thr) & ~r_prev_dac,
                   (adc_fifo_level >= r_adc_thr) & ~r_prev_adc};
   assign w_w1c = (w_acc_wr && avs.slave_address == A_PEND) ? avs.slave_writedata[3:0] : 4'd0;

   // Zero-latency strobes are gated by reset so they stay quiet while Rst_n is low.
   assign wr_i2c      = Rst_n & w_acc_wr & (avs.slave_address == A_I2C);
   assign rd_adc_fifo = Rst_n & w_acc_rd & (avs.slave_address == A_ADC);
   // Bypass the register so the packet is valid in the same cycle as the strobe.
   assign i2c_packet  = wr_i2c ? avs.slave_writedata[I2C_W-1:0] : r_i2c_cmd[I2C_W-1:0];

   assign w_adc_lvl16 = 16'(adc_fifo_level);
   assign w_dac_lvl12 = 12'(dac_fifo_level);
   assign w_adc_thr16 = 16'(r_adc_thr);
   assign w_dac_thr16 = 16'(r_dac_thr);

   always_comb begin
      w_rdata = '0;
      if (w_acc_rd) begin
         case (avs.slave_address)
            A_I2C:   w_rdata = r_i2c_cmd;
            A_STAT:  w_rdata = {w_adc_lvl16, w_dac_lvl12, adc_fifo_empty, 1'b0,
                                dac_fifo_full, i2c_idle};
            A_ADC:   w_rdata = 32'(adc_fifo_out);
            A_MASK:  w_rdata = {28'd0, r_mask};
            A_PEND:  w_rdata = {28'd0, r_pend};
            A_THR:   w_rdata = {w_dac_thr16, w_adc_thr16};
            A_BURST: w_rdata = {22'd0, 2'(r_state), r_remaining};
            default: w_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_i2c_cmd   <= '0;
         r_dac_in    <= '0;
         r_wr_dac    <= 1'b0;
         r_mask      <= '0;
         r_pend      <= '0;
         r_adc_thr   <= '0;
         r_dac_thr   <= '0;
         r_remaining <= '0;
         r_state     <= IDLE;
         r_prev_adc  <= 1'b0;
         r_prev_dac  <= 1'b0;
         r_prev_idle <= 1'b1;
         r_irq       <= 1'b0;
      end else begin
         if (w_acc_wr) begin
            case (avs.slave_address)
               A_I2C:  r_i2c_cmd <= avs.slave_writedata;
               A_MASK: r_mask    <= avs.slave_writedata[3:0];
               A_THR: begin
                  r_adc_thr <= avs.slave_writedata[LVL_W-1:0];
                  r_dac_thr <= avs.slave_writedata[16+LVL_W-1:16];
               end
               default: ;
            endcase
         end
         r_wr_dac <= w_acc_wr && (avs.slave_address == A_DAC);
         if (w_acc_wr && avs.slave_address == A_DAC)
            r_dac_in <= avs.slave_writedata[DATA_W-1:0];

         r_pend      <= (r_pend & ~w_w1c) | w_set;
         r_irq       <= |(r_pend & r_mask);
         r_prev_adc  <= adc_fifo_level >= r_adc_thr;
         r_prev_dac  <= dac_fifo_level <= r_dac_thr;
         r_prev_idle <= i2c_idle;

         // Opposite-direction beats are stalled by waitrequest, so any beat here matches.
         case (r_state)
            IDLE: begin
               if (w_beat && avs.slave_beginbursttransfer && w_rem_load != 8'd0) begin
                  r_remaining <= w_rem_load;
                  r_state     <= w_acc_rd ? RBURST : WBURST;
               end
            end
            RBURST, WBURST: begin
               if (w_beat) begin
                  r_remaining <= r_remaining - 8'd1;
                  if (r_remaining == 8'd1)
                     r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign avs.slave_waitrequest = w_wait;
   assign avs.slave_readdata    = w_rdata;
   assign avs.slave_irq         = r_irq;
   assign wr_dac_fifo           = r_wr_dac;
   assign dac_fifo_in           = r_dac_in;

endmodule

// File: tb/tb_codec_avalon_slave_v2.sv
// Self-checking bench for codec_avalon_slave_v2: directed scenarios plus randomized register,
// status and burst traffic checked against expectations derived from the register map rules.
module tb_codec_avalon_slave_v2;
   localparam int DATA_W = 32;
   localparam int I2C_W  = 24;
   localparam int LVL_W  = 8;

   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   always #5 Clk = ~Clk;

   codec_avalon_slave_v2_if bus();
   logic              i2c_idle, wr_i2c, adc_fifo_empty, rd_adc_fifo, dac_fifo_full, wr_dac_fifo;
   logic [I2C_W-1:0]  i2c_packet;
   logic [LVL_W-1:0]  adc_fifo_level, dac_fifo_level;
   logic [DATA_W-1:0] adc_fifo_out, dac_fifo_in;

   codec_avalon_slave_v2 #(.DATA_W(DATA_W), .I2C_W(I2C_W), .LVL_W(LVL_W)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .avs(bus.slave),
      .i2c_idle(i2c_idle), .i2c_packet(i2c_packet), .wr_i2c(wr_i2c),
      .adc_fifo_empty(adc_fifo_empty), .adc_fifo_level(adc_fifo_level),
      .adc_fifo_out(adc_fifo_out), .rd_adc_fifo(rd_adc_fifo),
      .dac_fifo_full(dac_fifo_full), .dac_fifo_level(dac_fifo_level),
      .dac_fifo_in(dac_fifo_in), .wr_dac_fifo(wr_dac_fifo)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned cyc = 0;
   int          n_pop = 0;
   logic [31:0] push_q[$];
   int unsigned push_c[$];
   logic        cap_wr_i2c;
   logic [I2C_W-1:0] cap_pkt;
   logic [31:0] m_i2c = '0;

   // Scoreboard capture of FIFO side effects, sampled on the active edge.
   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (Rst_n && wr_dac_fifo) begin
         push_q.push_back(32'(dac_fifo_in));
         push_c.push_back(cyc);
      end
      if (rd_adc_fifo) n_pop <= n_pop + 1;
   end

   task automatic bus_idle();
      bus.slave_chipselect = 1'b0; bus.slave_read = 1'b0; bus.slave_write = 1'b0;
      bus.slave_address = 3'd0; bus.slave_writedata = '0;
      bus.slave_beginbursttransfer = 1'b0; bus.slave_burstcount = 8'd0;
   endtask

   // One beat, held until accepted; returns just after the accepting edge.
   task automatic beat(input bit wr, input logic [2:0] a, input logic [31:0] d,
                       input bit bb, input logic [7:0] bc, output logic [31:0] rdata);
      int waits = 0;
      bus.slave_chipselect = 1'b1; bus.slave_read = !wr; bus.slave_write = wr;
      bus.slave_address = a; bus.slave_writedata = d;
      bus.slave_beginbursttransfer = bb; bus.slave_burstcount = bc;
      #2;
      while (bus.slave_waitrequest !== 1'b0 && waits < 40) begin
         @(posedge Clk); #2; waits++;
      end
      if (waits >= 40) begin
         n_cmp++; n_err++;
         $display("FAIL beat_timeout: waitrequest=%b after %0d cycles, required 0", bus.slave_waitrequest, waits);
      end
      rdata = bus.slave_readdata; cap_wr_i2c = wr_i2c; cap_pkt = i2c_packet;
      @(posedge Clk); #1;
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      logic [31:0] unused;
      beat(1'b1, a, d, 1'b0, 8'd0, unused);
      if (a == 3'd0) m_i2c = d;
      bus_idle();
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
      beat(1'b0, a, 32'd0, 1'b0, 8'd0, d);
      bus_idle();
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic [2:0]  addrs [5] = '{3'd0, 3'd4, 3'd6, 3'd7, 3'd5};
      logic [31:0] exps  [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h3};
      bus.slave_chipselect = 1'b1; bus.slave_read = 1'b1; bus.slave_address = 3'd3;
      adc_fifo_empty = 1'b0;
      #2;
      n_cmp++;
      if ({wr_i2c, rd_adc_fifo, wr_dac_fifo, bus.slave_irq} !== 4'b0) begin
         n_err++;
         $display("FAIL reset_strobes: got %b required 0000", {wr_i2c, rd_adc_fifo, wr_dac_fifo, bus.slave_irq});
      end
      bus_idle(); adc_fifo_empty = 1'b1;
      @(negedge Clk); Rst_n = 1'b1;
      @(posedge Clk); #1;
      // Levels 0 with thresholds 0 make both level sources rise at release; idle source must not.
      foreach (addrs[i]) begin
         rd_reg(addrs[i], rd);
         n_cmp++;
         if (rd !== exps[i]) begin
            n_err++; $display("FAIL reset_reg%0d: got %h required %h", addrs[i], rd, exps[i]);
         end
      end
   endtask

   task automatic test_i2c();
      logic [31:0] rd;
      bus.slave_chipselect = 1'b1; bus.slave_write = 1'b1; bus.slave_address = 3'd0;
      bus.slave_writedata = 32'h00AB_CDEF;
      #2;
      n_cmp++;
      if ({bus.slave_waitrequest, wr_i2c, i2c_packet} !== {1'b0, 1'b1, 24'hABCDEF}) begin
         n_err++; $display("FAIL i2c_launch: got wait=%b strobe=%b pkt=%h required 0 1 abcdef", bus.slave_waitrequest, wr_i2c, i2c_packet);
      end
      @(posedge Clk); #1; bus_idle(); #1;
      n_cmp++;
      if ({wr_i2c, i2c_packet} !== {1'b0, 24'hABCDEF}) begin
         n_err++; $display("FAIL i2c_after: got strobe=%b pkt=%h required 0 abcdef", wr_i2c, i2c_packet);
      end
      i2c_idle = 1'b0;
      bus.slave_chipselect = 1'b1; bus.slave_write = 1'b1; bus.slave_address = 3'd0;
      bus.slave_writedata = 32'h0012_3456;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if ({bus.slave_waitrequest, wr_i2c} !== 2'b10) begin
            n_err++; $display("FAIL i2c_busy_wait%0d: got wait=%b strobe=%b required 1 0", i, bus.slave_waitrequest, wr_i2c);
         end
         @(posedge Clk); #1;
      end
      i2c_idle = 1'b1; #1;
      n_cmp++;
      if ({bus.slave_waitrequest, wr_i2c, i2c_packet} !== {1'b0, 1'b1, 24'h123456}) begin
         n_err++; $display("FAIL i2c_release: got wait=%b strobe=%b pkt=%h required 0 1 123456", bus.slave_waitrequest, wr_i2c, i2c_packet);
      end
      m_i2c = 32'h0012_3456;
      @(posedge Clk); #1; bus_idle();
      rd_reg(3'd5, rd);
      n_cmp++;
      if (rd !== 32'h7) begin n_err++; $display("FAIL i2c_idle_pend: got %h required 00000007", rd); end
      wr_reg(3'd5, 32'hF);
      rd_reg(3'd5, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL pend_w1c_all: got %h required 00000000", rd); end
   endtask

   task automatic test_regs_random();
      logic [2:0]  sel [3] = '{3'd0, 3'd4, 3'd6};
      logic [31:0] d, rd, exp;
      logic [2:0]  a;
      for (int i = 0; i < 8; i++) begin
         a = sel[$urandom_range(0, 2)];
         d = $urandom;
         wr_reg(a, d);
         if (a == 3'd0) begin
            n_cmp++;
            if ({cap_wr_i2c, cap_pkt} !== {1'b1, d[23:0]}) begin
               n_err++; $display("FAIL rand_i2c_pkt: got strobe=%b pkt=%h required 1 %h", cap_wr_i2c, cap_pkt, d[23:0]);
            end
         end
         exp = (a == 3'd0) ? d : (a == 3'd4) ? (d & 32'hF) : (d & 32'h00FF_00FF);
         rd_reg(a, rd);
         n_cmp++;
         if (rd !== exp) begin n_err++; $display("FAIL rand_reg%0d: got %h required %h", a, rd, exp); end
      end
   endtask

   task automatic test_status_random();
      logic [31:0] rd, exp;
      for (int i = 0; i < 6; i++) begin
         adc_fifo_level = LVL_W'($urandom); dac_fifo_level = LVL_W'($urandom);
         adc_fifo_empty = 1'($urandom); dac_fifo_full = 1'($urandom); i2c_idle = 1'($urandom);
         exp = (32'(adc_fifo_level) << 16) | (32'(dac_fifo_level) << 4) |
               (32'(adc_fifo_empty) << 3) | (32'(dac_fifo_full) << 1) | 32'(i2c_idle);
         rd_reg(3'd1, rd);
         n_cmp++;
         if (rd !== exp) begin n_err++; $display("FAIL rand_status: got %h required %h", rd, exp); end
      end
      adc_fifo_empty = 1'b1; dac_fifo_full = 1'b0; i2c_idle = 1'b1;
      adc_fifo_level = '0; dac_fifo_level = '0;
      @(posedge Clk); #1;
   endtask

   task automatic test_irq();
      logic [31:0] rd;
      dac_fifo_level = 8'd5; adc_fifo_level = 8'd7;
      wr_reg(3'd6, 32'h0000_0008);
      wr_reg(3'd4, 32'h1);
      wr_reg(3'd5, 32'hF);
      rd_reg(3'd5, rd);
      n_cmp++;
      if ({rd, bus.slave_irq} !== {32'h0, 1'b0}) begin
         n_err++; $display("FAIL irq_clean: got pend=%h irq=%b required 0 0", rd, bus.slave_irq);
      end
      adc_fifo_level = 8'd8;
      @(posedge Clk); #1;
      n_cmp++;
      if (bus.slave_irq !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b required 0", bus.slave_irq); end
      @(posedge Clk); #1;
      n_cmp++;
      if (bus.slave_irq !== 1'b1) begin n_err++; $display("FAIL irq_raise: got %b required 1", bus.slave_irq); end
      rd_reg(3'd5, rd);
      n_cmp++;
      if (rd !== 32'h1) begin n_err++; $display("FAIL irq_pend_thr: got %h required 00000001", rd); end
      wr_reg(3'd5, 32'h1);
      rd_reg(3'd5, rd);
      n_cmp++;
      if ({rd, bus.slave_irq} !== {32'h0, 1'b0}) begin
         n_err++; $display("FAIL irq_w1c: got pend=%h irq=%b required 0 0", rd, bus.slave_irq);
      end
      adc_fifo_level = 8'd7;
      @(posedge Clk); #1;
      adc_fifo_level = 8'd8;
      wr_reg(3'd5, 32'h1);
      rd_reg(3'd5, rd);
      n_cmp++;
      if ({rd, bus.slave_irq} !== {32'h1, 1'b1}) begin
         n_err++; $display("FAIL irq_set_wins: got pend=%h irq=%b required 1 1", rd, bus.slave_irq);
      end
      wr_reg(3'd4, 32'h0);
      wr_reg(3'd5, 32'hF);
   endtask

   task automatic test_dac_burst();
      logic [31:0] rd;
      int unsigned c0;
      dac_fifo_full = 1'b0; dac_fifo_level = 8'd5;
      wr_reg(3'd5, 32'h8);
      push_q.delete(); push_c.delete();
      beat(1'b1, 3'd2, 32'd1, 1'b1, 8'd4, rd);
      c0 = cyc;
      for (int k = 2; k <= 4; k++) beat(1'b1, 3'd2, 32'(k), 1'b0, 8'd0, rd);
      bus_idle();
      repeat (2) @(posedge Clk); #1;
      n_cmp++;
      if (push_q.size() != 4) begin n_err++; $display("FAIL dac_push_count: got %0d required 4", push_q.size()); end
      for (int i = 0; i < 4 && i < push_q.size(); i++) begin
         n_cmp++;
         if (push_q[i] !== 32'(i + 1) || push_c[i] != c0 + i) begin
            n_err++; $display("FAIL dac_push%0d: got data=%h cycle=%0d required %h %0d", i, push_q[i], push_c[i], i + 1, c0 + i);
         end
      end
      rd_reg(3'd7, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL dac_burst_idle: got %h required 00000000", rd); end
      rd_reg(3'd5, rd);
      n_cmp++;
      if (rd[3] !== 1'b1) begin n_err++; $display("FAIL burst_done_pend: got %h required bit3 set", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic [31:0] data[$];
      int unsigned c0;
      int n;
      n = $urandom_range(3, 8);
      for (int i = 0; i < n; i++) data.push_back($urandom);
      push_q.delete(); push_c.delete();
      beat(1'b1, 3'd2, data[0], 1'b1, 8'(n), rd);
      c0 = cyc;
      bus.slave_read = 1'b1; bus.slave_write = 1'b0; bus.slave_address = 3'd7; #1;
      n_cmp++;
      if (bus.slave_waitrequest !== 1'b1) begin n_err++; $display("FAIL wburst_read_stall: got %b required 1", bus.slave_waitrequest); end
      for (int k = 1; k < n; k++) beat(1'b1, 3'd2, data[k], 1'b0, 8'd0, rd);
      bus_idle();
      repeat (2) @(posedge Clk); #1;
      n_cmp++;
      if (push_q.size() != n) begin n_err++; $display("FAIL b2b_count: got %0d required %0d", push_q.size(), n); end
      for (int i = 0; i < n && i < push_q.size(); i++) begin
         n_cmp++;
         if (push_q[i] !== data[i] || push_c[i] != c0 + i) begin
            n_err++; $display("FAIL b2b_push%0d: got data=%h cycle=%0d required %h %0d", i, push_q[i], push_c[i], data[i], c0 + i);
         end
      end
   endtask

   task automatic test_read_burst();
      logic [31:0] rd, exp;
      int n;
      n = $urandom_range(2, 8);
      beat(1'b0, 3'd7, 32'd0, 1'b1, 8'(n), rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL rburst_first: got %h required 00000000", rd); end
      bus.slave_read = 1'b0; bus.slave_write = 1'b1; bus.slave_address = 3'd4;
      bus.slave_writedata = 32'hF; #1;
      n_cmp++;
      if (bus.slave_waitrequest !== 1'b1) begin n_err++; $display("FAIL rburst_write_stall: got %b required 1", bus.slave_waitrequest); end
      for (int k = 2; k <= n; k++) begin
         exp = 32'h100 | 32'(n - k + 1);
         beat(1'b0, 3'd7, 32'd0, 1'b0, 8'd0, rd);
         n_cmp++;
         if (rd !== exp) begin n_err++; $display("FAIL rburst_beat%0d: got %h required %h", k, rd, exp); end
      end
      bus_idle();
      rd_reg(3'd7, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL rburst_end: got %h required 00000000", rd); end
      rd_reg(3'd4, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL rburst_mask_untouched: got %h required 00000000", rd); end
      beat(1'b0, 3'd7, 32'd0, 1'b1, 8'd0, rd);
      bus_idle();
      rd_reg(3'd7, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL burstcount0_idle: got %h required 00000000", rd); end
   endtask

   task automatic test_adc_read();
      int p0;
      p0 = n_pop;
      adc_fifo_out = 32'h1234; adc_fifo_empty = 1'b1;
      bus.slave_chipselect = 1'b1; bus.slave_read = 1'b1; bus.slave_address = 3'd3;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++;
         if ({bus.slave_waitrequest, rd_adc_fifo} !== 2'b10) begin
            n_err++; $display("FAIL adc_empty_wait%0d: got wait=%b pop=%b required 1 0", i, bus.slave_waitrequest, rd_adc_fifo);
         end
         @(posedge Clk); #1;
      end
      adc_fifo_empty = 1'b0; #1;
      n_cmp++;
      if ({bus.slave_waitrequest, rd_adc_fifo, bus.slave_readdata} !== {1'b0, 1'b1, 32'h1234}) begin
         n_err++; $display("FAIL adc_read: got wait=%b pop=%b data=%h required 0 1 00001234", bus.slave_waitrequest, rd_adc_fifo, bus.slave_readdata);
      end
      @(posedge Clk); #1; bus_idle(); adc_fifo_empty = 1'b1;
      @(posedge Clk); #1;
      n_cmp++;
      if (n_pop - p0 != 1) begin n_err++; $display("FAIL adc_pop_count: got %0d required 1", n_pop - p0); end
   endtask

   task automatic test_dac_flow_and_rw();
      logic [31:0] rd;
      dac_fifo_full = 1'b1; dac_fifo_level = 8'd5;
      bus.slave_chipselect = 1'b1; bus.slave_write = 1'b1; bus.slave_address = 3'd2;
      bus.slave_writedata = 32'hA5; #1;
      n_cmp++;
      if (bus.slave_waitrequest !== 1'b1) begin n_err++; $display("FAIL dac_full_wait: got %b required 1", bus.slave_waitrequest); end
      @(posedge Clk); #1;
      dac_fifo_full = 1'b0;
      @(posedge Clk); #1;
      dac_fifo_level = 8'hFF; bus.slave_writedata = 32'h5A; #1;
      n_cmp++;
      if (bus.slave_waitrequest !== 1'b1) begin n_err++; $display("FAIL dac_pending_full_wait: got %b required 1", bus.slave_waitrequest); end
      @(posedge Clk); #1;
      n_cmp++;
      if (bus.slave_waitrequest !== 1'b0) begin n_err++; $display("FAIL dac_level_max_ok: got %b required 0", bus.slave_waitrequest); end
      @(posedge Clk); #1; bus_idle(); dac_fifo_level = 8'd5;
      bus.slave_chipselect = 1'b1; bus.slave_read = 1'b1; bus.slave_write = 1'b1;
      bus.slave_address = 3'd0; bus.slave_writedata = 32'hDEAD_BEEF; #1;
      n_cmp++;
      if ({bus.slave_waitrequest, wr_i2c, bus.slave_readdata} !== 34'd0) begin
         n_err++; $display("FAIL rw_both: got wait=%b strobe=%b data=%h required 0 0 0", bus.slave_waitrequest, wr_i2c, bus.slave_readdata);
      end
      @(posedge Clk); #1; bus_idle();
      rd_reg(3'd0, rd);
      n_cmp++;
      if (rd !== m_i2c) begin n_err++; $display("FAIL rw_both_no_effect: got %h required %h", rd, m_i2c); end
   endtask

   task automatic test_reset_mid_burst();
      logic [31:0] rd;
      beat(1'b0, 3'd7, 32'd0, 1'b1, 8'd4, rd);
      bus_idle();
      Rst_n = 1'b0; #1;
      n_cmp++;
      if ({wr_i2c, rd_adc_fifo, wr_dac_fifo, bus.slave_irq} !== 4'b0) begin
         n_err++; $display("FAIL midburst_reset_strobes: got %b required 0000", {wr_i2c, rd_adc_fifo, wr_dac_fifo, bus.slave_irq});
      end
      @(negedge Clk); Rst_n = 1'b1;
      @(posedge Clk); #1;
      rd_reg(3'd7, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL midburst_reset_idle: got %h required 00000000", rd); end
      beat(1'b0, 3'd7, 32'd0, 1'b1, 8'd2, rd);
      beat(1'b0, 3'd7, 32'd0, 1'b0, 8'd0, rd);
      bus_idle();
      n_cmp++;
      if (rd !== 32'h101) begin n_err++; $display("FAIL post_reset_burst: got %h required 00000101", rd); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_idle();
      i2c_idle = 1'b1; adc_fifo_empty = 1'b1; dac_fifo_full = 1'b0;
      adc_fifo_level = '0; dac_fifo_level = '0; adc_fifo_out = '0;
      repeat (2) @(posedge Clk); #1;
      test_reset();
      test_i2c();
      test_regs_random();
      test_status_random();
      test_irq();
      test_dac_burst();
      test_back_to_back();
      test_read_burst();
      test_adc_read();
      test_dac_flow_and_rw();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
